stack_op_sequencer: RTL and testbench
=====================================

Name: stack_op_sequencer

Overview:
- Sequences push, pop and peek operations on the hardware stack.
- Drives the stack-pointer register's write enable and next-value input, plus the word-addressed data-memory port.
- Sits between the control unit (requester) and the SP register / data memory.
- Checks overflow and underflow, and returns results through a valid/ready response channel.

Parameters:
- WIDTH, 16, data and address width.
- SP_TOP, 1016, SP value when the stack is empty; the SP register's reset value.
- SP_LIMIT, 768, lowest legal SP; a push while SP == SP_LIMIT is overflow.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_op  input  2  00 PUSH, 01 POP, 10 PEEK, 11 reserved.
- req_data  input  WIDTH  push data.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- resp_data  output  WIDTH  popped/peeked word; 0 for push or error.
- resp_err  output  1  overflow, underflow or illegal op.
- sp_in  input  WIDTH  current SP register output.
- sp_write  output  1  SP register write enable.
- sp_new  output  WIDTH  value loaded into the SP register when sp_write = 1.
- mem_addr  output  WIDTH  data-memory address.
- mem_wdata  output  WIDTH  data-memory write data.
- mem_write  output  1  memory write strobe.
- mem_read  output  1  memory read strobe; mem_rdata is valid exactly 1 cycle later.
- mem_rdata  input  WIDTH  memory read data.

Behaviour:
- Stack model: full-descending, one word per entry.
  - Push: SP <- SP-1, then mem[SP] <- data.
  - Pop: data <- mem[SP], then SP <- SP+1.
  - Peek: data <- mem[SP]; SP unchanged.
- Reset (asynchronous, any state, including mid-operation):
  - State goes to IDLE.
  - All outputs 0 except req_ready = 1.
  - Latched op and data registers cleared.
  - A partially completed push/pop is abandoned; the SP register resets independently to SP_TOP.
- States: IDLE, PUSH_DEC, PUSH_WR, RD_ISSUE, RD_CAPTURE, RESP.
- Outputs are Moore-decoded from state; sp_write, mem_write and mem_read are 0 outside their listed states.
- IDLE:
  - req_ready = 1. On req_valid, latch req_op and req_data.
  - PUSH with sp_in == SP_LIMIT: RESP with err = 1.
  - POP or PEEK with sp_in == SP_TOP: RESP with err = 1.
  - Op 11: RESP with err = 1.
  - Otherwise: PUSH goes to PUSH_DEC; POP or PEEK goes to RD_ISSUE.
  - Error paths issue no sp_write and no memory access.
- PUSH_DEC: sp_write = 1, sp_new = sp_in - 1 (modulo 2^WIDTH); next state PUSH_WR.
- PUSH_WR: mem_addr = sp_in (already updated), mem_wdata = latched data, mem_write = 1; next state RESP.
- RD_ISSUE: mem_addr = sp_in, mem_read = 1; next state RD_CAPTURE.
- RD_CAPTURE:
  - Register mem_rdata into resp_data.
  - For POP only: sp_write = 1, sp_new = sp_in + 1.
  - Next state RESP.
- RESP:
  - resp_valid = 1; resp_data and resp_err held stable.
  - On resp_ready, go to IDLE and clear resp_data and resp_err.
  - No new request is accepted until IDLE (req_ready = 0 in every non-IDLE state).
- Latency, counted as edges from the acceptance edge to the edge on which resp_valid first samples 1:
  - PUSH: 3.
  - POP and PEEK: 3.
  - Error: 1.
- Minimum throughput: one operation per 4 cycles (push/pop) with resp_ready tied high.
- sp_in is assumed stable except when written by this block; no other SP writer exists while the sequencer is outside IDLE.

Test Plan:
1. Reset, sp_in = 1016; PUSH 0xBEEF.
   - Required: PUSH_DEC shows sp_write = 1, sp_new = 1015.
   - Next cycle: mem_write = 1, mem_addr = 1015, mem_wdata = 0xBEEF.
   - Next cycle: resp_valid = 1, resp_err = 0.
2. After test 1 (SP = 1015, mem[1015] = 0xBEEF); POP.
   - Required: mem_read at address 1015.
   - Next cycle: sp_write = 1, sp_new = 1016.
   - Then: resp_data = 0xBEEF, resp_err = 0.
3. PEEK with SP = 1015.
   - Required: resp_data = mem[1015] and no sp_write in any cycle.
4. SP = 1016; POP.
   - Required: next cycle resp_err = 1 and resp_data = 0.
   - No sp_write, mem_read or mem_write asserted.
5. SP = 768; PUSH 0x1234.
   - Required: resp_err = 1 and SP stays 768.
6. Backpressure and reset:
   - Hold resp_ready = 0 for 5 cycles: resp_valid and resp_data stay stable and req_ready = 0 throughout.
   - Assert reset during PUSH_WR: all outputs clear immediately, and mem_write stays low after reset release.

Source files
------------

// File: rtl/stack_op_sequencer.sv
// rtl/stack_op_sequencer.sv - push/pop/peek sequencer for a full-descending hardware stack
module stack_op_sequencer #(
    parameter int WIDTH    = 16,
    parameter int SP_TOP   = 1016,
    parameter int SP_LIMIT = 768
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_data,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_err,
    input  logic [WIDTH-1:0] sp_in,
    output logic             sp_write,
    output logic [WIDTH-1:0] sp_new,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_write,
    output logic             mem_read,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_PUSH_DEC   = 3'd1;
    localparam logic [2:0] S_PUSH_WR    = 3'd2;
    localparam logic [2:0] S_RD_ISSUE   = 3'd3;
    localparam logic [2:0] S_RD_CAPTURE = 3'd4;
    localparam logic [2:0] S_RESP       = 3'd5;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_PEEK = 2'b10;

    localparam logic [WIDTH-1:0] SP_TOP_W   = WIDTH'(SP_TOP);
    localparam logic [WIDTH-1:0] SP_LIMIT_W = WIDTH'(SP_LIMIT);

    logic [2:0]       state;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic             req_bad;

    // Overflow, underflow and the reserved opcode all short-circuit straight to RESP.
    always_comb begin
        req_bad = 1'b0;
        case (req_op)
            OP_PUSH: req_bad = (sp_in == SP_LIMIT_W);
            OP_POP:  req_bad = (sp_in == SP_TOP_W);
            OP_PEEK: req_bad = (sp_in == SP_TOP_W);
            default: req_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            op_q      <= 2'b00;
            data_q    <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q   <= req_op;
                        data_q <= req_data;
                        if (req_bad) begin
                            resp_err  <= 1'b1;
                            resp_data <= '0;
                            state     <= S_RESP;
                        end else if (req_op == OP_PUSH) begin
                            state <= S_PUSH_DEC;
                        end else begin
                            state <= S_RD_ISSUE;
                        end
                    end
                end
                S_PUSH_DEC:   state <= S_PUSH_WR;
                S_PUSH_WR:    state <= S_RESP;
                S_RD_ISSUE:   state <= S_RD_CAPTURE;
                S_RD_CAPTURE: begin
                    resp_data <= mem_rdata;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_data <= '0;
                        resp_err  <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        sp_write   = 1'b0;
        sp_new     = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        case (state)
            S_IDLE:     req_ready = 1'b1;
            S_PUSH_DEC: begin
                sp_write = 1'b1;
                sp_new   = sp_in - 1'b1;
            end
            // sp_in already reflects the decrement written in PUSH_DEC.
            S_PUSH_WR: begin
                mem_addr  = sp_in;
                mem_wdata = data_q;
                mem_write = 1'b1;
            end
            S_RD_ISSUE: begin
                mem_addr = sp_in;
                mem_read = 1'b1;
            end
            S_RD_CAPTURE: begin
                if (op_q == OP_POP) begin
                    sp_write = 1'b1;
                    sp_new   = sp_in + 1'b1;
                end
            end
            S_RESP:     resp_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// tb/tb_stack_op_sequencer.sv - self-checking bench for stack_op_sequencer
module tb_stack_op_sequencer;

    localparam int WIDTH    = 16;
    localparam int SP_TOP   = 1016;
    localparam int SP_LIMIT = 768;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = 2'b00;
    logic [WIDTH-1:0] req_data = '0;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic [WIDTH-1:0] resp_data;
    logic             resp_err;
    logic [WIDTH-1:0] sp_reg;
    logic             sp_write;
    logic [WIDTH-1:0] sp_new;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_write;
    logic             mem_read;
    logic [WIDTH-1:0] mem_rdata;

    logic             sp_load = 1'b0;
    logic [WIDTH-1:0] sp_load_val = '0;
    logic [WIDTH-1:0] mem [0:1023];

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] q[$];
    int               mdl_sp = SP_TOP;

    always #5 clk = ~clk;

    stack_op_sequencer #(.WIDTH(WIDTH), .SP_TOP(SP_TOP), .SP_LIMIT(SP_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
        .sp_in(sp_reg), .sp_write(sp_write), .sp_new(sp_new),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
        .mem_rdata(mem_rdata)
    );

    // External SP register and one-cycle-latency data memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        sp_reg <= WIDTH'(SP_TOP);
        else if (sp_load) sp_reg <= sp_load_val;
        else if (sp_write) sp_reg <= sp_new;
    end

    always_ff @(posedge clk) begin
        if (mem_write) mem[mem_addr[9:0]] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem[mem_addr[9:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_sp(input int v);
        sp_load_val = WIDTH'(v);
        sp_load = 1'b1;
        @(negedge clk);
        sp_load = 1'b0;
        mdl_sp = v;
    endtask

    // Issues one request from IDLE (at a negedge) and checks it end to end against the queue model.
    task automatic op_run(input logic [1:0] op, input logic [WIDTH-1:0] data, input int hold);
        bit               err;
        logic [WIDTH-1:0] exp_data;
        int               sp_b, exp_sp, lat, n_sw, n_mw, n_mr, exp_lat;
        logic [2:0]       exp_strobes;
        logic [WIDTH-1:0] held;
        sp_b = mdl_sp;
        err = (op == 2'b11) || (op == 2'b00 && mdl_sp == SP_LIMIT)
              || (op != 2'b00 && mdl_sp == SP_TOP);
        exp_data = (err || op == 2'b00) ? '0 : q[$];
        exp_sp = err ? mdl_sp : (op == 2'b00 ? mdl_sp - 1 : (op == 2'b01 ? mdl_sp + 1 : mdl_sp));
        exp_lat = err ? 1 : 3;
        if (err)               exp_strobes = 3'b000;
        else if (op == 2'b00)  exp_strobes = 3'b110;
        else if (op == 2'b01)  exp_strobes = 3'b101;
        else                   exp_strobes = 3'b001;

        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_data = data;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1; n_sw = 0; n_mw = 0; n_mr = 0;
        while (!resp_valid && lat < 8) begin
            if (req_ready) chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
            if (sp_write) begin
                n_sw++;
                chk("sp_new", {16'd0, sp_new}, (op == 2'b00) ? sp_b - 1 : sp_b + 1);
            end
            if (mem_write) begin
                n_mw++;
                chk("push_addr", {16'd0, mem_addr}, sp_b - 1);
                chk("push_wdata", {16'd0, mem_wdata}, {16'd0, data});
            end
            if (mem_read) begin
                n_mr++;
                chk("read_addr", {16'd0, mem_addr}, sp_b);
            end
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("strobes", {29'd0, n_sw != 0, n_mw != 0, n_mr != 0}, {29'd0, exp_strobes});
        chk("strobe_count", n_sw + n_mw + n_mr, (n_sw != 0) + (n_mw != 0) + (n_mr != 0));
        chk("resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("resp_err", {31'd0, resp_err}, {31'd0, err});
        chk("resp_data", {16'd0, resp_data}, {16'd0, exp_data});
        held = resp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_data", {16'd0, resp_data}, {16'd0, held});
            chk("hold_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("resp_cleared", {15'd0, resp_valid, resp_err, resp_data}, 32'd0);
        chk("sp_after", {16'd0, sp_reg}, exp_sp);
        if (!err) begin
            if (op == 2'b00) q.push_back(data);
            else if (op == 2'b01) void'(q.pop_back());
        end
        mdl_sp = exp_sp;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_outputs", {resp_valid, resp_err, sp_write, mem_write, mem_read, resp_data},
            32'd0);
        chk("rst_buses", {sp_new, mem_addr}, 32'd0);
        chk("rst_wdata", {16'd0, mem_wdata}, 32'd0);
        chk("rst_sp", {16'd0, sp_reg}, SP_TOP);

        // Test 1: push 0xBEEF with cycle-by-cycle checks.
        req_valid = 1'b1; req_op = 2'b00; req_data = 16'hBEEF;
        @(negedge clk);
        req_valid = 1'b0;
        chk("t1_dec", {sp_write, mem_write, mem_read, 13'd0, sp_new}, {3'b100, 13'd0, 16'd1015});
        @(negedge clk);
        chk("t1_wr", {mem_write, mem_read, sp_write, 13'd0, mem_addr}, {3'b100, 13'd0, 16'd1015});
        chk("t1_wdata", {16'd0, mem_wdata}, 32'h0000BEEF);
        @(negedge clk);
        chk("t1_resp", {30'd0, resp_valid, resp_err}, 32'd2);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        q.push_back(16'hBEEF);
        mdl_sp = SP_TOP - 1;
        chk("t1_sp", {16'd0, sp_reg}, 1015);

        // Tests 2-4: pop, push+peek, drain, then underflow.
        op_run(2'b01, 16'h0, 0);
        op_run(2'b00, 16'h5A5A, 1);
        op_run(2'b10, 16'h0, 0);
        op_run(2'b01, 16'h0, 0);
        op_run(2'b01, 16'h0, 0);
        op_run(2'b10, 16'h0, 0);
        op_run(2'b11, 16'h0, 0);

        // Test 5: overflow at the limit leaves SP untouched.
        load_sp(SP_LIMIT);
        op_run(2'b00, 16'h1234, 0);
        chk("t5_sp", {16'd0, sp_reg}, SP_LIMIT);
        load_sp(SP_TOP);

        for (int n = 0; n < 60; n++) begin
            int r;
            r = $urandom_range(0, 9);
            op_run(r < 4 ? 2'b00 : (r < 7 ? 2'b01 : (r < 9 ? 2'b10 : 2'b11)),
                   WIDTH'($urandom), $urandom_range(0, 3));
        end

        // Test 6: backpressure, then reset in PUSH_WR.
        op_run(2'b00, 16'hC0DE, 5);
        req_valid = 1'b1; req_op = 2'b00; req_data = 16'h7777;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("t6_in_wr", {31'd0, mem_write}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("t6_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("t6_rst_out", {resp_valid, resp_err, sp_write, mem_write, mem_read, resp_data}, 32'd0);
        chk("t6_rst_bus", {sp_new, mem_addr}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        mdl_sp = SP_TOP;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_write", {30'd0, mem_write, req_ready}, 32'd1);
        end
        chk("t6_sp", {16'd0, sp_reg}, SP_TOP);
        op_run(2'b01, 16'h0, 0);
        op_run(2'b00, 16'h4321, 0);
        op_run(2'b01, 16'h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
